trunc_wb_scheduler: RTL and testbench

Shares one truncate stage and the output-memory write port between NREQ convolution/accumulation engines. Each engine offers a wide fixed-point accumulator result plus destination address over a valid/ready handshake. The block grants requesters round-robin, truncates the winning result to DATA width, drives a registered write to output memory with back-pressure, and counts completed writes against a programmed total to signal layer completion.

---
 rtl/trunc_wb_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_trunc_wb_scheduler.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trunc_wb_scheduler.sv
// trunc_wb_scheduler: round-robin arbiter that shares one truncate stage and
// the output-memory write port between NREQ accumulator engines, counting
// completed writes against a per-layer total.
// Optional build macro TRUNC_SAT_EN: saturating truncation instead of wrap.
module trunc_wb_scheduler #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned IN_W   = 40,
    parameter int unsigned OUT_W  = 16,
    parameter int unsigned FRAC   = 8,
    parameter int unsigned ADDR_W = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      total_cnt,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*IN_W-1:0]   req_data,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    output logic [NREQ-1:0]        req_ready,
    input  logic                   mem_busy,
    output logic                   mem_wen,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [OUT_W-1:0]       mem_wdata,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_total;
    logic [ADDR_W-1:0]   r_acc_cnt;
    logic [ADDR_W-1:0]   r_wr_cnt;
    logic [IDX_W-1:0]    r_rr;
    logic                r_mem_wen;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [OUT_W-1:0]    r_mem_wdata;

    logic                w_slot_free;
    logic                w_can_grant;
    logic                w_wr_fire;
    logic                w_last_wr;
    logic                w_found;
    logic [NREQ-1:0]     w_hi_mask;
    logic [NREQ-1:0]     w_hi_req;
    logic [NREQ-1:0]     w_pick_src;
    logic [NREQ-1:0]     w_pick_oh;
    logic [IDX_W-1:0]    w_pick_idx;
    logic [IDX_W-1:0]    w_rr_nxt;
    logic [NREQ-1:0]     w_grant;
    logic [IN_W-1:0]     w_sel_data;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [OUT_W-1:0]    w_trunc;
`ifdef TRUNC_SAT_EN
    logic [IN_W-FRAC-OUT_W:0] w_upper;
`endif

    assign w_slot_free = ~r_mem_wen | ~mem_busy;
    assign w_wr_fire   = r_mem_wen & ~mem_busy;
    assign w_last_wr   = w_wr_fire & ((r_wr_cnt + ADDR_W'(1)) == r_total);
    assign w_can_grant = (r_state == S_RUN) & w_slot_free & (r_acc_cnt < r_total);

    // Round-robin pick: lowest valid at or above the pointer, else lowest valid overall
    always_comb begin
        w_hi_mask  = '0;
        w_pick_oh  = '0;
        w_pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDX_W'(i) >= r_rr) begin
                w_hi_mask[i] = 1'b1;
            end
        end
        w_hi_req   = req_valid & w_hi_mask;
        w_pick_src = (|w_hi_req) ? w_hi_req : req_valid;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_pick_src[i]) begin
                w_pick_oh    = '0;
                w_pick_oh[i] = 1'b1;
                w_pick_idx   = IDX_W'(i);
            end
        end
        w_grant  = w_can_grant ? w_pick_oh : '0;
        w_found  = |w_grant;
        w_rr_nxt = (w_pick_idx == IDX_W'(NREQ - 1)) ? '0 : (w_pick_idx + IDX_W'(1));
    end

    // Select the granted payload and truncate it to the stored width
    always_comb begin
        w_sel_data = '0;
        w_sel_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_data = w_sel_data | req_data[i*IN_W +: IN_W];
                w_sel_addr = w_sel_addr | req_addr[i*ADDR_W +: ADDR_W];
            end
        end
        w_trunc = OUT_W'(w_sel_data >> FRAC);
`ifdef TRUNC_SAT_EN
        w_upper = w_sel_data[IN_W-1:FRAC+OUT_W-1];
        if (!(&w_upper) && (|w_upper)) begin
            w_trunc = w_sel_data[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                         : {1'b0, {(OUT_W-1){1'b1}}};
        end
`endif
    end

    // Layer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Layer sequencing: start, completion on the last write, one-cycle done
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (total_cnt == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last_wr) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Counters, round-robin pointer and the registered write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_total     <= '0;
            r_acc_cnt   <= '0;
            r_wr_cnt    <= '0;
            r_rr        <= '0;
            r_mem_wen   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_total   <= total_cnt;
                r_acc_cnt <= '0;
                r_wr_cnt  <= '0;
            end else begin
                if (w_found) begin
                    r_acc_cnt <= r_acc_cnt + ADDR_W'(1);
                end
                if (w_wr_fire) begin
                    r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
                end
            end
            if (w_found) begin
                r_mem_wen   <= 1'b1;
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_trunc;
                r_rr        <= w_rr_nxt;
            end else if (w_slot_free) begin
                r_mem_wen <= 1'b0;
            end
        end
    end

    assign req_ready = w_grant;
    assign mem_wen   = r_mem_wen;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_trunc_wb_scheduler.sv
// Self-checking bench for trunc_wb_scheduler: per-cycle reference model,
// truncation vector table, directed multi-cycle sequences and random layers.
module tb_trunc_wb_scheduler;

    localparam int NREQ   = 4;
    localparam int IN_W   = 40;
    localparam int OUT_W  = 16;
    localparam int FRAC   = 8;
    localparam int ADDR_W = 12;

    localparam int ST_IDLE = 0;
    localparam int ST_RUN  = 1;
    localparam int ST_DONE = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   start;
    logic [ADDR_W-1:0]      total_cnt;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*IN_W-1:0]   req_data;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ-1:0]        req_ready;
    logic                   mem_busy;
    logic                   mem_wen;
    logic [ADDR_W-1:0]      mem_addr;
    logic [OUT_W-1:0]       mem_wdata;
    logic                   busy;
    logic                   done;

    trunc_wb_scheduler #(
        .NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .FRAC(FRAC), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .total_cnt(total_cnt),
        .req_valid(req_valid), .req_data(req_data), .req_addr(req_addr),
        .req_ready(req_ready), .mem_busy(mem_busy), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state (spec-level quantities as plain integers)
    int               m_st, m_total, m_acc, m_wr, m_rr;
    bit               m_wen;
    logic [ADDR_W-1:0] m_addr;
    logic [OUT_W-1:0]  m_wdata;

    // Values observed at the last sampling edge
    logic [NREQ-1:0]   o_ready;
    logic              o_wen, o_busy, o_done, o_mbusy;
    logic [ADDR_W-1:0] o_addr;
    logic [OUT_W-1:0]  o_wdata;

    typedef struct {
        logic [IN_W-1:0]   data;
        logic [ADDR_W-1:0] addr;
        logic [OUT_W-1:0]  exp_wrap;
        logic [OUT_W-1:0]  exp_sat;
    } tv_t;
    tv_t tv[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Floor-divide by 2^FRAC, then wrap or clamp into a signed OUT_W value
    function automatic logic [OUT_W-1:0] ref_trunc(input logic [IN_W-1:0] x);
        longint sx;
        longint q;
        sx = longint'($signed(x));
        q  = sx >>> FRAC;
`ifdef TRUNC_SAT_EN
        if (q > 32767)  return 16'h7FFF;
        if (q < -32768) return 16'h8000;
`endif
        return OUT_W'(q);
    endfunction

    task automatic model_reset();
        m_st = ST_IDLE; m_total = 0; m_acc = 0; m_wr = 0; m_rr = 0;
        m_wen = 1'b0; m_addr = '0; m_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic [IN_W-1:0] d, input logic [ADDR_W-1:0] a);
        req_data[i*IN_W +: IN_W]       = d;
        req_addr[i*ADDR_W +: ADDR_W]   = a;
    endtask

    // One clock: sample and compare at negedge, advance the model across posedge
    task automatic step();
        int g;
        int src;
        bit sf;
        bit fire;
        logic [NREQ-1:0] exp_rdy;
        @(negedge clk);
        o_ready = req_ready; o_wen = mem_wen; o_addr = mem_addr;
        o_wdata = mem_wdata; o_busy = busy; o_done = done; o_mbusy = mem_busy;
        chk("cyc_wen",   64'(o_wen),   64'(m_wen));
        chk("cyc_addr",  64'(o_addr),  64'(m_addr));
        chk("cyc_wdata", 64'(o_wdata), 64'(m_wdata));
        chk("cyc_busy",  64'(o_busy),  64'(m_st == ST_RUN));
        chk("cyc_done",  64'(o_done),  64'(m_st == ST_DONE));
        sf = !m_wen || !mem_busy;
        g  = -1;
        if (m_st == ST_RUN && sf && m_acc < m_total) begin
            for (int k = 0; k < NREQ; k++) begin
                src = (m_rr + k) % NREQ;
                if (g < 0 && req_valid[src]) g = src;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("cyc_ready", 64'(o_ready), 64'(exp_rdy));
        fire = m_wen && !mem_busy;
        @(posedge clk);
        if (g >= 0) begin
            m_wen   = 1'b1;
            m_addr  = req_addr[g*ADDR_W +: ADDR_W];
            m_wdata = ref_trunc(req_data[g*IN_W +: IN_W]);
            m_acc++;
            m_rr    = (g + 1) % NREQ;
        end else if (sf) begin
            m_wen = 1'b0;
        end
        if (fire) m_wr++;
        case (m_st)
            ST_IDLE: if (start) begin
                m_total = int'(total_cnt);
                m_acc   = 0;
                m_wr    = 0;
                m_st    = (total_cnt == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN:  if (fire && m_wr == m_total) m_st = ST_DONE;
            default: m_st = ST_IDLE;
        endcase
        #1;
    endtask

    task automatic quiet_inputs();
        start = 1'b0; total_cnt = '0; req_valid = '0; mem_busy = 1'b0;
    endtask

    // Asynchronous reset with an immediate check that every output cleared
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk({tag, "_ready"}, 64'(req_ready), 64'(0));
        chk({tag, "_wen"},   64'(mem_wen),   64'(0));
        chk({tag, "_addr"},  64'(mem_addr),  64'(0));
        chk({tag, "_wdata"}, 64'(mem_wdata), 64'(0));
        chk({tag, "_busy"},  64'(busy),      64'(0));
        chk({tag, "_done"},  64'(done),      64'(0));
        quiet_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic start_layer(input int total);
        start = 1'b1;
        total_cnt = ADDR_W'(total);
        step();
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy, wen, dn, gcnt, wcnt, first_g, last_g, bad, idx, after_done;
        logic [OUT_W-1:0]  got_d;
        logic [ADDR_W-1:0] got_a;
        logic [OUT_W-1:0]  exp_d;
        logic [ADDR_W-1:0] held_a;
        logic [63:0]       r;
        int gl[$];

        tv[0] = '{40'h0000123456, 12'd5,   16'h1234, 16'h1234};
        tv[1] = '{40'h0001000000, 12'd17,  16'h0000, 16'h7FFF};
        tv[2] = '{40'hFF00000000, 12'd300, 16'h0000, 16'h8000};
        tv[3] = '{40'hFFFF800000, 12'hABC, 16'h8000, 16'h8000};
        tv[4] = '{40'hFFFFFFFF00, 12'hFFF, 16'hFFFF, 16'hFFFF};

        req_data = '0;
        req_addr = '0;
        quiet_inputs();
        do_reset("rst");

        // Truncation table: one single-write layer per vector
        for (int t = 0; t < 5; t++) begin
            idx = t % NREQ;
`ifdef TRUNC_SAT_EN
            exp_d = tv[t].exp_sat;
`else
            exp_d = tv[t].exp_wrap;
`endif
            start_layer(1);
            set_req(idx, tv[t].data, tv[t].addr);
            req_valid = '0;
            req_valid[idx] = 1'b1;
            rdy = -1; wen = -1; dn = -1; got_d = '0; got_a = '0;
            for (int c = 0; c < 20 && dn < 0; c++) begin
                step();
                if (o_ready != '0 && rdy < 0) begin rdy = c; req_valid = '0; end
                if (o_wen && wen < 0) begin wen = c; got_d = o_wdata; got_a = o_addr; end
                if (o_done) dn = c;
            end
            req_valid = '0;
            chk("tv_done_seen", 64'(dn >= 0), 64'(1));
            chk("tv_wdata", 64'(got_d), 64'(exp_d));
            chk("tv_addr", 64'(got_a), 64'(tv[t].addr));
            chk("tv_wen_latency", 64'(wen - rdy), 64'(1));
            chk("tv_done_latency", 64'(dn - wen), 64'(1));
            step();
            chk("tv_busy_after", 64'(o_busy), 64'(0));
        end

        // Fairness: all requesters valid, pointer fresh from reset
        do_reset("fair_rst");
        for (int i = 0; i < NREQ; i++) set_req(i, IN_W'(64'(i + 1) << 12), ADDR_W'(i + 100));
        start_layer(8);
        req_valid = '1;
        gl.delete(); dn = -1; wcnt = 0; first_g = -1; last_g = -1;
        for (int c = 0; c < 40 && dn < 0; c++) begin
            step();
            for (int i = 0; i < NREQ; i++)
                if (o_ready[i]) begin
                    gl.push_back(i);
                    if (first_g < 0) first_g = c;
                    last_g = c;
                end
            if (o_wen && !o_mbusy) wcnt++;
            if (o_done) dn = c;
        end
        req_valid = '0;
        chk("fair_grants", 64'(gl.size()), 64'(8));
        for (int k = 0; k < gl.size(); k++) chk("fair_order", 64'(gl[k]), 64'(k % NREQ));
        chk("fair_back_to_back", 64'(last_g - first_g), 64'(7));
        chk("fair_writes", 64'(wcnt), 64'(8));
        chk("fair_done_lat", 64'(dn - last_g), 64'(2));

        // Back-pressure: memory stalls three cycles on the first write
        start_layer(3);
        set_req(1, 40'h0000ABCD00, 12'd42);
        req_valid = 4'b0010;
        dn = -1; wcnt = 0; bad = 0; held_a = '0; got_d = '0;
        for (int c = 0; c < 40 && dn < 0; c++) begin
            mem_busy = (c >= 1 && c <= 3);
            if (c == 4) set_req(1, 40'h0000BEEF00, 12'd43);
            step();
            if (c == 1) begin held_a = o_addr; got_d = o_wdata; end
            if (c >= 1 && c <= 3) begin
                if (!o_wen || o_ready != '0 || o_addr != held_a || o_wdata != got_d) bad++;
            end
            if (o_wen && !o_mbusy) wcnt++;
            if (o_done) dn = c;
        end
        mem_busy = 1'b0;
        req_valid = '0;
        chk("bp_hold", 64'(bad), 64'(0));
        chk("bp_first_addr", 64'(held_a), 64'(42));
        chk("bp_first_data", 64'(got_d), 64'(16'hABCD));
        chk("bp_writes", 64'(wcnt), 64'(3));
        chk("bp_done_cycle", 64'(dn), 64'(7));

        // Over-offer: requesters stay valid past the programmed total
        start_layer(2);
        req_valid = '1;
        gcnt = 0; wcnt = 0; dn = -1; after_done = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (o_ready != '0) begin gcnt++; if (dn >= 0) after_done++; end
            if (o_wen && !o_mbusy) wcnt++;
            if (o_done) dn = c;
        end
        req_valid = '0;
        chk("over_grants", 64'(gcnt), 64'(2));
        chk("over_writes", 64'(wcnt), 64'(2));
        chk("over_no_late_grant", 64'(after_done), 64'(0));

        // Zero-length layer finishes immediately with no writes
        req_valid = '1;
        start_layer(0);
        step();
        chk("zero_done", 64'(o_done), 64'(1));
        chk("zero_no_wen", 64'(o_wen), 64'(0));
        chk("zero_no_ready", 64'(o_ready), 64'(0));
        step();
        chk("zero_done_pulse", 64'(o_done), 64'(0));
        req_valid = '0;

        // Reset in the middle of a layer with a write pending
        start_layer(5);
        req_valid = '1;
        wen = 0;
        for (int c = 0; c < 10 && !wen; c++) begin
            step();
            if (o_wen) wen = 1;
        end
        chk("mid_wen_seen", 64'(mem_wen), 64'(1));
        #2;
        do_reset("mid_rst");
        start_layer(2);
        req_valid = 4'b0100;
        dn = -1; wcnt = 0;
        for (int c = 0; c < 20 && dn < 0; c++) begin
            step();
            if (o_wen && !o_mbusy) wcnt++;
            if (o_done) dn = c;
        end
        req_valid = '0;
        chk("mid_clean_done", 64'(dn >= 0), 64'(1));
        chk("mid_clean_writes", 64'(wcnt), 64'(2));

        // Random layers: random valids, payloads and memory stalls
        for (int l = 0; l < 12; l++) begin
            int tot;
            tot = int'($urandom_range(1, 12));
            start_layer(tot);
            dn = -1; wcnt = 0;
            for (int c = 0; c < 400 && dn < 0; c++) begin
                req_valid = NREQ'($urandom);
                for (int i = 0; i < NREQ; i++) begin
                    r = {$urandom, $urandom};
                    set_req(i, r[IN_W-1:0], ADDR_W'($urandom));
                end
                mem_busy = ($urandom_range(0, 2) == 0);
                step();
                if (o_wen && !o_mbusy) wcnt++;
                if (o_done) dn = c;
            end
            req_valid = '0;
            mem_busy = 1'b0;
            chk("rand_done_seen", 64'(dn >= 0), 64'(1));
            chk("rand_writes", 64'(wcnt), 64'(tot));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
